// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: RV64 funct3 encodings,
// FSM states and the size/legality decoders used at request accept.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } lsu_state_t;

   function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         2'b10:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   // Unsigned stores do not exist, and every size must sit on its natural boundary.
   function automatic logic access_ok(input logic write, input logic [2:0] funct3,
                                      input logic [2:0] offset);
      logic ok;
      ok = 1'b1;
      if (funct3 == 3'b111) ok = 1'b0;
      if (write && funct3[2]) ok = 1'b0;
      case (funct3[1:0])
         2'b01:   if (offset[0] != 1'b0) ok = 1'b0;
         2'b10:   if (offset[1:0] != 2'b00) ok = 1'b0;
         2'b11:   if (offset != 3'b000) ok = 1'b0;
         default: ;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and memory-side signals of the load/store unit.
// The slave modport is the unit itself; master is its environment.
interface lsu_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_funct3;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_error;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_addr, mem_read, mem_write, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_addr, mem_read, mem_write, mem_wdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data, and merges
// store bytes into the fetched memory word (little-endian lanes).
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int WORD_BYTES_POW = 3
) (
   input  logic [DATA_WIDTH-1:0]     word_i,
   input  logic [WORD_BYTES_POW-1:0] offset_i,
   input  logic [2:0]                funct3_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   output logic [DATA_WIDTH-1:0]     load_data_o,
   output logic [DATA_WIDTH-1:0]     merged_word_o
);

   localparam int WORD_BYTES = 1 << WORD_BYTES_POW;

   logic [WORD_BYTES_POW+2:0] shamt;
   logic [DATA_WIDTH-1:0]     shiftedWord;
   logic [DATA_WIDTH-1:0]     shiftedWdata;
   logic                      signedLoad;
   logic [3:0]                sizeB;

   assign shamt        = {offset_i, 3'b000};
   assign shiftedWord  = word_i >> shamt;
   assign shiftedWdata = wdata_i << shamt;
   assign sizeB        = size_bytes(funct3_i);
   assign signedLoad   = !((funct3_i == F3_BU) || (funct3_i == F3_HU) || (funct3_i == F3_WU));

   always_comb begin
      load_data_o = shiftedWord;
      case (funct3_i[1:0])
         F3_B[1:0]: load_data_o = {{(DATA_WIDTH-8){signedLoad & shiftedWord[7]}},
                                   shiftedWord[7:0]};
         F3_H[1:0]: load_data_o = {{(DATA_WIDTH-16){signedLoad & shiftedWord[15]}},
                                   shiftedWord[15:0]};
         F3_W[1:0]: load_data_o = {{(DATA_WIDTH-32){signedLoad & shiftedWord[31]}},
                                   shiftedWord[31:0]};
         default:   load_data_o = shiftedWord;
      endcase
   end

   // A doubleword covers every lane, so it degenerates to the store data itself.
   always_comb begin
      merged_word_o = word_i;
      for (int k = 0; k < WORD_BYTES; k++) begin
         if ((k >= int'(offset_i)) && (k < int'(offset_i) + int'(sizeB)))
            merged_word_o[8*k +: 8] = shiftedWdata[8*k +: 8];
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit in front of a word-addressed memory: sub-word loads,
// read-modify-write sub-word stores, and error responses for bad accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH_POW = 6,
   parameter int ADDR_WIDTH_POW = 6,
   parameter int WORD_BYTES_POW = 3
) (
   input logic  clk_in,
   input logic  reset_n,
   lsu_if.slave bus
);

   localparam int DATA_WIDTH = 1 << DATA_WIDTH_POW;
   localparam int ADDR_WIDTH = 1 << ADDR_WIDTH_POW;

   lsu_state_t            state_q, state_d;
   logic                  write_q;
   logic                  error_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] word_q;

   logic                  accept;
   logic                  reqOk;
   logic [DATA_WIDTH-1:0] loadData;
   logic [DATA_WIDTH-1:0] mergedWord;

   assign accept = bus.req_valid && (state_q == IDLE);
   assign reqOk  = access_ok(bus.req_write, bus.req_funct3,
                             bus.req_addr[WORD_BYTES_POW-1:0]);

   lsu_lane_align #(
      .DATA_WIDTH     (DATA_WIDTH),
      .WORD_BYTES_POW (WORD_BYTES_POW)
   ) u_lane_align (
      .word_i        (word_q),
      .offset_i      (addr_q[WORD_BYTES_POW-1:0]),
      .funct3_i      (funct3_q),
      .wdata_i       (wdata_q),
      .load_data_o   (loadData),
      .merged_word_o (mergedWord)
   );

   assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:WORD_BYTES_POW], {WORD_BYTES_POW{1'b0}}};
   assign bus.mem_wdata = mergedWord;

   always_ff @(posedge clk_in) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         write_q  <= 1'b0;
         error_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
      end else begin
         if (accept) begin
            write_q  <= bus.req_write;
            error_q  <= !reqOk;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
         end
         if (state_q == READ) word_q <= bus.mem_rdata;
      end
   end

   // Gating mem_write with reset_n keeps a reset edge during WRITE from committing.
   always_comb begin
      state_d        = state_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = '0;
      bus.resp_error = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (!reqOk)
                  state_d = RESP;
               else if (bus.req_write && (bus.req_funct3 == F3_D))
                  state_d = WRITE;
               else
                  state_d = READ;
            end
         end
         READ: begin
            bus.mem_read = 1'b1;
            state_d      = write_q ? WRITE : RESP;
         end
         WRITE: begin
            bus.mem_write = reset_n;
            state_d       = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_error = error_q;
            if (!write_q && !error_q) bus.resp_rdata = loadData;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions
// against a word memory model, plus reset-abort and back-to-back sequences.
module tb_load_store_unit;

   typedef struct {
      logic        write;
      logic [2:0]  funct3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] expRdata;
      logic        expError;
      int          expLat;
      int          expReads;
      int          expWrites;
      logic [63:0] expMemWdata;
   } vec_t;

   localparam int NVEC = 21;

   logic        clock = 1'b0;
   logic        resetN;
   logic        presetEn;
   logic [5:0]  presetIdx;
   logic [63:0] presetVal;
   logic [63:0] mem [0:63];
   int          checksTotal = 0;
   int          checksPassed = 0;
   int          overlapCount = 0;

   lsu_if bus ();

   load_store_unit dut (
      .clk_in  (clock),
      .reset_n (resetN),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   assign bus.mem_rdata = mem[bus.mem_addr[8:3]];

   always @(posedge clock) begin
      if (bus.mem_write)  mem[bus.mem_addr[8:3]] <= bus.mem_wdata;
      else if (presetEn)  mem[presetIdx] <= presetVal;
   end

   always @(negedge clock) begin
      if (bus.mem_read && bus.mem_write) overlapCount <= overlapCount + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic driveReq(input vec_t v);
      bus.req_write  = v.write;
      bus.req_funct3 = v.funct3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
   endtask

   // Latency counts negedges from the accept edge until resp_valid is seen.
   task automatic applyStimulus(input vec_t v, input string tag);
      int          cyc, reads, writes, waitCyc;
      logic        gotResp, err;
      logic [63:0] rdata, seenWdata;
      @(negedge clock);
      driveReq(v);
      bus.req_valid = 1'b1;
      waitCyc = 0;
      while (!bus.req_ready && waitCyc < 20) begin
         @(negedge clock);
         waitCyc++;
      end
      checkOutput({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
      @(posedge clock);
      cyc = 0; reads = 0; writes = 0;
      gotResp = 1'b0; err = 1'b0; rdata = '0; seenWdata = '0;
      while (!gotResp && cyc < 10) begin
         @(negedge clock);
         bus.req_valid = 1'b0;
         cyc++;
         if (bus.mem_read) reads++;
         if (bus.mem_write) begin
            writes++;
            seenWdata = bus.mem_wdata;
         end
         if (bus.resp_valid) begin
            gotResp = 1'b1;
            rdata   = bus.resp_rdata;
            err     = bus.resp_error;
         end
      end
      checkOutput({tag, ".latency"}, 64'(cyc), 64'(v.expLat));
      checkOutput({tag, ".rdata"}, rdata, v.expRdata);
      checkOutput({tag, ".error"}, 64'(err), 64'(v.expError));
      checkOutput({tag, ".reads"}, 64'(reads), 64'(v.expReads));
      checkOutput({tag, ".writes"}, 64'(writes), 64'(v.expWrites));
      if (v.expWrites != 0) checkOutput({tag, ".memWdata"}, seenWdata, v.expMemWdata);
      @(negedge clock);
      checkOutput({tag, ".afterResp"}, {62'd0, bus.req_ready, bus.resp_valid}, 64'd2);
   endtask

   task automatic runResetAbort();
      vec_t sb;
      int   waitCyc;
      logic sawPulse;
      sb = '{1'b1, 3'b000, 64'h10, 64'h77, 64'h0, 1'b0, 0, 0, 0, 64'h0};
      @(negedge clock);
      driveReq(sb);
      bus.req_valid = 1'b1;
      @(negedge clock);
      bus.req_valid = 1'b0;
      waitCyc = 0;
      while (!bus.mem_write && waitCyc < 6) begin
         @(negedge clock);
         waitCyc++;
      end
      checkOutput("abort.reachedWrite", 64'(bus.mem_write), 64'd1);
      resetN = 1'b0;
      #1;
      checkOutput("abort.writeGated", 64'(bus.mem_write), 64'd0);
      @(negedge clock);
      checkOutput("abort.ready", 64'(bus.req_ready), 64'd1);
      checkOutput("abort.noResp", 64'(bus.resp_valid), 64'd0);
      checkOutput("abort.memKept", mem[2], 64'h8877_6655_ABCD_2211);
      resetN = 1'b1;
      sawPulse = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (bus.resp_valid) sawPulse = 1'b1;
      end
      checkOutput("abort.noLatePulse", 64'(sawPulse), 64'd0);
   endtask

   task automatic runBackToBack();
      vec_t        q [3];
      logic [63:0] expData [3];
      logic [63:0] gotData [3];
      int          idx, accepts, pulses;
      logic        switchNext;
      q[0] = '{1'b0, 3'b011, 64'h10, 64'h0, 64'h0, 1'b0, 0, 0, 0, 64'h0};
      q[1] = '{1'b1, 3'b011, 64'h30, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0, 0, 0, 64'h0};
      q[2] = '{1'b0, 3'b010, 64'h34, 64'h0, 64'h0, 1'b0, 0, 0, 0, 64'h0};
      expData[0] = 64'h8877_6655_ABCD_2211;
      expData[1] = 64'h0;
      expData[2] = 64'h0000_0000_0123_4567;
      for (int i = 0; i < 3; i++) gotData[i] = '1;
      @(negedge clock);
      driveReq(q[0]);
      bus.req_valid = 1'b1;
      idx = 0; accepts = 0; pulses = 0; switchNext = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (bus.req_valid && bus.req_ready) begin
            accepts++;
            switchNext = 1'b1;
         end
         @(negedge clock);
         if (bus.resp_valid) begin
            if (pulses < 3) gotData[pulses] = bus.resp_rdata;
            pulses++;
         end
         if (switchNext) begin
            switchNext = 1'b0;
            idx++;
            if (idx < 3) driveReq(q[idx]);
            else bus.req_valid = 1'b0;
         end
      end
      checkOutput("b2b.accepts", 64'(accepts), 64'd3);
      checkOutput("b2b.pulses", 64'(pulses), 64'd3);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("b2b.rdata%0d", i), gotData[i], expData[i]);
   endtask

   initial begin
      vec_t vecs [NVEC];
      vec_t ldBack;
      //              wr    f3      addr    wdata                   expRdata                err  lat rd wr memWdata
      vecs[0]  = '{1'b0, 3'b000, 64'h17, 64'h0,                  64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2, 1, 0, 64'h0};
      vecs[1]  = '{1'b0, 3'b100, 64'h17, 64'h0,                  64'h0000_0000_0000_0088, 1'b0, 2, 1, 0, 64'h0};
      vecs[2]  = '{1'b0, 3'b001, 64'h16, 64'h0,                  64'hFFFF_FFFF_FFFF_8877, 1'b0, 2, 1, 0, 64'h0};
      vecs[3]  = '{1'b0, 3'b101, 64'h14, 64'h0,                  64'h0000_0000_0000_6655, 1'b0, 2, 1, 0, 64'h0};
      vecs[4]  = '{1'b1, 3'b001, 64'h12, 64'h1111_2222_3333_ABCD, 64'h0,                  1'b0, 3, 1, 1, 64'h8877_6655_ABCD_2211};
      vecs[5]  = '{1'b0, 3'b011, 64'h10, 64'h0,                  64'h8877_6655_ABCD_2211, 1'b0, 2, 1, 0, 64'h0};
      vecs[6]  = '{1'b1, 3'b011, 64'h20, 64'hDEAD_BEEF_0123_4567, 64'h0,                  1'b0, 2, 0, 1, 64'hDEAD_BEEF_0123_4567};
      vecs[7]  = '{1'b0, 3'b110, 64'h24, 64'h0,                  64'h0000_0000_DEAD_BEEF, 1'b0, 2, 1, 0, 64'h0};
      vecs[8]  = '{1'b0, 3'b010, 64'h24, 64'h0,                  64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 2, 1, 0, 64'h0};
      vecs[9]  = '{1'b0, 3'b010, 64'h20, 64'h0,                  64'h0000_0000_0123_4567, 1'b0, 2, 1, 0, 64'h0};
      vecs[10] = '{1'b1, 3'b000, 64'h21, 64'h0000_0000_0000_FF99, 64'h0,                  1'b0, 3, 1, 1, 64'hDEAD_BEEF_0123_9967};
      vecs[11] = '{1'b1, 3'b010, 64'h24, 64'h0000_0000_CAFE_F00D, 64'h0,                  1'b0, 3, 1, 1, 64'hCAFE_F00D_0123_9967};
      vecs[12] = '{1'b0, 3'b000, 64'h21, 64'h0,                  64'hFFFF_FFFF_FFFF_FF99, 1'b0, 2, 1, 0, 64'h0};
      vecs[13] = '{1'b0, 3'b010, 64'h22, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0};
      vecs[14] = '{1'b1, 3'b100, 64'h20, 64'h0000_0000_0000_0055, 64'h0,                  1'b1, 1, 0, 0, 64'h0};
      vecs[15] = '{1'b0, 3'b011, 64'h14, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0};
      vecs[16] = '{1'b0, 3'b111, 64'h10, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0};
      vecs[17] = '{1'b1, 3'b001, 64'h13, 64'h0000_0000_0000_1234, 64'h0,                  1'b1, 1, 0, 0, 64'h0};
      vecs[18] = '{1'b0, 3'b001, 64'h11, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0};
      vecs[19] = '{1'b0, 3'b011, 64'h20, 64'h0,                  64'hCAFE_F00D_0123_9967, 1'b0, 2, 1, 0, 64'h0};
      vecs[20] = '{1'b0, 3'b001, 64'h26, 64'h0,                  64'hFFFF_FFFF_FFFF_CAFE, 1'b0, 2, 1, 0, 64'h0};
      ldBack   = '{1'b0, 3'b011, 64'h10, 64'h0,                  64'h8877_6655_ABCD_2211, 1'b0, 2, 1, 0, 64'h0};

      resetN         = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      presetEn       = 1'b1;
      presetIdx      = 6'd2;
      presetVal      = 64'h8877_6655_4433_2211;
      repeat (2) @(negedge clock);
      checkOutput("reset.ready", 64'(bus.req_ready), 64'd1);
      checkOutput("reset.respValid", 64'(bus.resp_valid), 64'd0);
      checkOutput("reset.respRdata", bus.resp_rdata, 64'd0);
      checkOutput("reset.respError", 64'(bus.resp_error), 64'd0);
      checkOutput("reset.memRdWr", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
      checkOutput("reset.memAddr", bus.mem_addr, 64'd0);
      presetEn = 1'b0;
      resetN   = 1'b1;

      for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

      runResetAbort();
      applyStimulus(ldBack, "abort.ldBack");
      runBackToBack();

      @(negedge clock);
      checkOutput("memRdWrOverlap", 64'(overlapCount), 64'd0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressable data memory (64-bit words, asynchronous read, synchronous write).
- Accepts RV64 load/store requests from the execute stage and performs sub-word access in front of the memory:
  - Loads: selects the byte lane, then sign- or zero-extends.
  - Stores: read-modify-write for SB/SH/SW.
- Flags misaligned and illegal-size accesses without touching memory.

Parameters:
- DATA_WIDTH_POW, 6, log2 of data width; DATA_WIDTH = 64.
- ADDR_WIDTH_POW, 6, log2 of address width; ADDR_WIDTH = 64.
- WORD_BYTES_POW, 3, log2 of bytes per memory word; WORD_BYTES = 8.

Ports:
- clk_in  input  1  Clock. All state changes on the rising edge.
- reset_n  input  1  Synchronous, active-low reset.
- req_valid  input  1  A request is present.
- req_ready  output  1  The unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (size in [1:0], unsigned in [2]).
- req_addr  input  ADDR_WIDTH  Byte address.
- req_wdata  input  DATA_WIDTH  Store data, right-aligned.
- resp_valid  output  1  One-cycle response pulse.
- resp_rdata  output  DATA_WIDTH  Extended load data; 0 for stores and errors.
- resp_error  output  1  Misaligned or illegal access; qualified by resp_valid.
- mem_addr  output  ADDR_WIDTH  Word-aligned address: {addr_q[63:3], 3'b000}.
- mem_read  output  1  Memory read enable.
- mem_write  output  1  Memory write enable.
- mem_wdata  output  DATA_WIDTH  Full word to write.
- mem_rdata  input  DATA_WIDTH  Asynchronous read data, valid in the same cycle as mem_read.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (reset_n=0 at an edge):
  - state=IDLE.
  - All request and data registers cleared to 0.
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - mem_read=0, mem_write=0.
- Reset mid-operation:
  - Any transaction in flight is abandoned and no response is issued.
  - mem_write is gated with reset_n, so no write commits at the reset edge.
- Accept: when req_valid && req_ready at an edge, latch write, funct3, addr and wdata into *_q registers.
- Legality, checked at accept:
  - funct3=111 is illegal.
  - A store with funct3[2]=1 is illegal.
  - Halfword requires addr[0]=0; word requires addr[1:0]=0; doubleword requires addr[2:0]=0.
  - An illegal or misaligned request goes directly to RESP with error=1. No mem_read or mem_write is ever asserted for it.
- Transitions for legal requests:
  - Load: IDLE -> READ -> RESP -> IDLE.
  - SD: IDLE -> WRITE -> RESP -> IDLE.
  - SB/SH/SW: IDLE -> READ -> WRITE -> RESP -> IDLE.
- READ state:
  - mem_read=1.
  - Register mem_rdata into word_q.
- WRITE state:
  - mem_write=1.
  - mem_wdata is the merged word: word_q with lanes [off .. off+size-1] replaced by the low bytes of wdata_q, where off=addr_q[2:0].
  - SD writes wdata_q unmodified.
- RESP state:
  - resp_valid=1 for exactly one cycle.
  - Load: resp_rdata = extracted lane value, sign-extended from its MSB if funct3[2]=0, else zero-extended.
  - Store or error: resp_rdata=0.
- Byte order: little-endian; byte k occupies bits [8k+7:8k].
- Latency from the accept edge to resp_valid high: error 1 cycle, load 2 cycles, SD 2 cycles, sub-word store 3 cycles.
- Throughput: no overlap; req_ready=0 from the accept edge until the edge that leaves RESP. A new request can therefore be accepted in the cycle after RESP.
- resp has no backpressure; the consumer must take the pulse.
- mem_read and mem_write are never high in the same cycle. mem_addr is stable from READ through WRITE.
- req_* inputs are ignored outside IDLE.

Decomposition:
- lsu_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_D=011, F3_BU=100, F3_HU=101, F3_WU=110.
  - typedef enum lsu_state_t {IDLE, READ, WRITE, RESP}.
  - Function size_bytes(funct3).
- One combinational sub-module, lsu_lane_align, implements:
  - Extract plus sign/zero-extend for loads.
  - Byte-lane merge for stores.
  - Inputs: word, offset, funct3, wdata. Outputs: load_data, merged_word.
- The FSM stays in load_store_unit.

Test Plan:
- Memory word @0x10 preset to 0x8877_6655_4433_2211, then LB addr 0x17 -> after 2 cycles resp_rdata=0xFFFF_FFFF_FFFF_FF88, error=0. LBU at the same address -> 0x0000_0000_0000_0088.
- Same preset word, then SH addr 0x12 wdata 0xABCD -> READ then WRITE with mem_wdata=0x8877_6655_ABCD_2211, resp after 3 cycles. A following LD 0x10 returns that value.
- SD addr 0x20 wdata 0xDEAD_BEEF_0123_4567 -> no mem_read, mem_write for 1 cycle, resp after 2 cycles. LWU 0x24 -> 0x0000_0000_DEAD_BEEF; LW 0x24 -> 0xFFFF_FFFF_DEAD_BEEF.
- LW addr 0x22 (misaligned) and a store with funct3=100 -> resp_error=1 one cycle after accept, resp_rdata=0, mem_read and mem_write stay 0 throughout.
- Start SB, assert reset_n=0 during WRITE -> no memory change at that edge, next cycle state IDLE, req_ready=1, resp_valid never pulses.
- Back-to-back requests held with req_valid=1 -> each is accepted only when req_ready=1, and there is exactly one resp_valid pulse per accepted request.
